array_struct_type_command_arbiter_mux_bus: RTL



---
 rtl/array_struct_type_command_arbiter_mux_bus.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/array_struct_type_command_arbiter_mux_bus.sv
// rtl/array_struct_type_command_arbiter_mux_bus.sv - two-lane command merge: per-lane FIFOs, round-robin arbiter, registered output
// Optional feature macro: CU_MUX_STRICT_PRIORITY_EN (ties always go to lane 1, READ_GRAPH_DATA).
module array_struct_type_command_arbiter_mux_bus #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_in_i       [0:BUS_WIDTH-1],
    input  logic [SEL_WIDTH-1:0]  sel_in_i        [0:BUS_WIDTH-1],
    input  logic                  data_in_valid_i [0:BUS_WIDTH-1],
    output logic                  data_in_ready_o [0:BUS_WIDTH-1],
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic [SEL_WIDTH-1:0]  sel_out_o,
    output logic                  data_out_valid_o,
    input  logic                  data_out_ready_i,
    output logic                  lane_grant_o
);
    localparam logic [SEL_WIDTH-1:0] STRUCT_INVALID = '0;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [ENT_W-1:0]      mem_q    [0:BUS_WIDTH-1][0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr_q [0:BUS_WIDTH-1];
    logic [PTR_W-1:0]      wr_ptr_d [0:BUS_WIDTH-1];
    logic [PTR_W-1:0]      rd_ptr_q [0:BUS_WIDTH-1];
    logic [PTR_W-1:0]      rd_ptr_d [0:BUS_WIDTH-1];
    logic [CNT_W-1:0]      count_q  [0:BUS_WIDTH-1];
    logic [CNT_W-1:0]      count_d  [0:BUS_WIDTH-1];
    logic [BUS_WIDTH-1:0]  push;
    logic [BUS_WIDTH-1:0]  pop;
    logic [BUS_WIDTH-1:0]  has_entry;
    logic                  out_free;
    logic                  win_any;
    logic                  win_lane;
    logic [ENT_W-1:0]      win_entry;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [SEL_WIDTH-1:0]  sel_out_q, sel_out_d;
    logic                  data_out_valid_q, data_out_valid_d;
    logic                  lane_grant_q, lane_grant_d;
    logic                  last_grant_q, last_grant_d;

    // Ready depends only on the registered count: a full FIFO refuses a push even while popping.
    always_comb begin
        for (int i = 0; i < BUS_WIDTH; i++) begin
            data_in_ready_o[i] = (count_q[i] != FULL_CNT);
            has_entry[i]       = (count_q[i] != '0);
            push[i]            = data_in_valid_i[i] & data_in_ready_o[i];
        end
    end

    always_comb begin
        out_free = !data_out_valid_q || data_out_ready_i;
        win_any  = |has_entry;
        if (&has_entry) begin
`ifdef CU_MUX_STRICT_PRIORITY_EN
            win_lane = 1'b1;
`else
            win_lane = ~last_grant_q;
`endif
        end else begin
            win_lane = has_entry[1];
        end
        pop = '0;
        if (out_free && win_any) begin
            pop[win_lane] = 1'b1;
        end
        win_entry = mem_q[win_lane][rd_ptr_q[win_lane]];
    end

    always_comb begin
        for (int i = 0; i < BUS_WIDTH; i++) begin
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
        end
        data_out_d       = data_out_q;
        sel_out_d        = sel_out_q;
        data_out_valid_d = data_out_valid_q;
        lane_grant_d     = lane_grant_q;
        last_grant_d     = last_grant_q;
        if (out_free) begin
            if (win_any) begin
                data_out_d       = win_entry[DATA_WIDTH-1:0];
                sel_out_d        = win_entry[ENT_W-1:DATA_WIDTH];
                data_out_valid_d = 1'b1;
                lane_grant_d     = win_lane;
                last_grant_d     = win_lane;
            end else begin
                // Idle: tag goes invalid, payload keeps its last value.
                data_out_valid_d = 1'b0;
                sel_out_d        = STRUCT_INVALID;
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUS_WIDTH; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            data_out_q       <= '0;
            sel_out_q        <= STRUCT_INVALID;
            data_out_valid_q <= 1'b0;
            lane_grant_q     <= 1'b0;
            last_grant_q     <= 1'b1;
        end else begin
            for (int i = 0; i < BUS_WIDTH; i++) begin
                count_q[i]  <= count_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            data_out_q       <= data_out_d;
            sel_out_q        <= sel_out_d;
            data_out_valid_q <= data_out_valid_d;
            lane_grant_q     <= lane_grant_d;
            last_grant_q     <= last_grant_d;
        end
    end

    // Storage needs no reset: the cleared counts make old entries unreachable.
    always_ff @(posedge clock) begin
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {sel_in_i[i], data_in_i[i]};
            end
        end
    end

    assign data_out_o       = data_out_q;
    assign sel_out_o        = sel_out_q;
    assign data_out_valid_o = data_out_valid_q;
    assign lane_grant_o     = lane_grant_q;

endmodule
